// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: prefix bytes, frame FSM states and the decoded event record.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO with level, full/empty and a dropped-push pulse.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  ps2_event_t               push_data,
    input  logic                     pop,
    output ps2_event_t               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    ps2_event_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign empty    = (count == '0);
    assign full     = (count == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign level    = count;
    assign head     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_event_receiver.sv
// PS/2 keyboard receiver: synchronises the pins, frames and checks bytes, strips E0/F0
// prefixes and queues make/break events behind a valid/ready interface.
module ps2_event_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [7:0]                    event_code,
    output logic                          event_break,
    output logic                          event_extended,
    output logic                          frame_error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output frame_state_e                  frame_state
);
    // Handshake: the head event transfers on any cycle where event_valid && event_ready;
    // event_valid never drops without a transfer and the head is stable while waiting.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   edge_found;
    logic                   data_bit;

    // Idle-high reset values keep a spurious falling edge from appearing after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_prev   <= 1'b1;
            edge_found <= 1'b0;
            data_bit   <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            edge_found <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            data_bit   <= data_sync[SYNC_STAGES-1];
        end
    end

    frame_state_e   state, state_nxt;
    logic [2:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shift, shift_nxt;
    logic           parity, parity_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic           timeout;
    logic           frame_done;
    logic           frame_bad;

    // An edge arriving in the expiry cycle keeps the frame alive.
    assign timeout = (state != IDLE) && !edge_found && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift   <= shift_nxt;
            parity  <= parity_nxt;
            if (state == IDLE || edge_found) wd_cnt <= '0;
            else                             wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        parity_nxt  = parity;
        frame_done  = 1'b0;
        frame_bad   = 1'b0;
        if (timeout) begin
            state_nxt = IDLE;
            frame_bad = 1'b1;
        end else if (edge_found) begin
            case (state)
                IDLE: begin
                    if (!data_bit) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {data_bit, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    parity_nxt = data_bit;
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if ((^shift ^ parity) && data_bit) frame_done = 1'b1;
                    else                               frame_bad  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic       ext_flag;
    logic       brk_flag;
    logic       push_req;
    ps2_event_t push_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            push_req    <= 1'b0;
            push_data   <= '0;
            frame_error <= 1'b0;
        end else begin
            push_req    <= 1'b0;
            frame_error <= frame_bad;
            if (frame_bad) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (frame_done) begin
                if (shift == PS2_PREFIX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (shift == PS2_PREFIX_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    push_req  <= 1'b1;
                    push_data <= {ext_flag, brk_flag, shift};
                    ext_flag  <= 1'b0;
                    brk_flag  <= 1'b0;
                end
            end
        end
    end

    ps2_event_t head;
    logic       fifo_empty;
    logic       fifo_full;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (push_data),
        .pop       (event_ready),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level),
        .overflow  (overflow)
    );

    assign event_valid    = !fifo_empty;
    assign event_code     = head.code;
    assign event_break    = head.brk;
    assign event_extended = head.extended;
    assign frame_state    = state;

endmodule

// File: tb/tb_ps2_event_receiver.sv
// Self-checking bench for ps2_event_receiver: drives PS/2 frames on the pins and scoreboards decoded events.
module tb_ps2_event_receiver;
    import ps2_pkg::*;

    localparam int SYNC_STAGES    = 2;
    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int HALF           = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic event_ready = 1'b0;
    logic event_valid;
    logic [7:0] event_code;
    logic event_break;
    logic event_extended;
    logic frame_error;
    logic overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    frame_state_e frame_state;

    int n_checks = 0;
    int n_errors = 0;
    int ferr_seen = 0;
    int ovf_seen = 0;
    int base;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    ps2_event_receiver #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_code     (event_code),
        .event_break    (event_break),
        .event_extended (event_extended),
        .frame_error    (frame_error),
        .overflow       (overflow),
        .fifo_level     (fifo_level),
        .frame_state    (frame_state)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard: outputs sampled on the falling edge, inputs driven 1 ns after the rising edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_error) ferr_seen++;
            if (overflow) ovf_seen++;
            if (event_valid && event_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_event", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_val("event", {22'd0, event_extended, event_break, event_code}, {22'd0, mon_exp});
                end
            end
        end
    end

    // drivers
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] b, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    // reference decoder: prefix flags and FIFO occupancy
    task automatic model_update(input logic [7:0] b, input bit bad, input bit pop_at_push);
        if (bad) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < FIFO_DEPTH || pop_at_push) exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad = 0, input bit pop_at_push = 0);
        logic par;
        par = (~^b) ^ bad;
        send_head(b, par);
        ps2_clk = 1'b0;
        model_update(b, bad, pop_at_push);
        if (pop_at_push) begin
            tick(SYNC_STAGES + 2);
            event_ready = 1'b1;
            tick(1);
            event_ready = 1'b0;
            tick(HALF - SYNC_STAGES - 3);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        tick(4);
        event_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        check_val("drain_done", 32'(exp_q.size()), 32'd0);
        event_ready = 1'b0;
        tick(2);
        check_val("empty_after_drain", 32'(event_valid), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check_val("rst_valid", 32'(event_valid), 32'd0);
        check_val("rst_level", 32'(fifo_level), 32'd0);
        check_val("rst_code", 32'(event_code), 32'd0);
        check_val("rst_state", 32'(frame_state), 32'(IDLE));

        // 1: single frame 0x1C with latency measured from the stop-bit fall
        send_head(8'h1C, 1'b0);
        ps2_clk = 1'b0;
        model_update(8'h1C, 0, 0);
        tick(SYNC_STAGES + 2);
        check_val("t1_not_early", 32'(event_valid), 32'd0);
        tick(1);
        check_val("t1_valid", 32'(event_valid), 32'd1);
        check_val("t1_code", 32'(event_code), 32'h1C);
        check_val("t1_break", 32'(event_break), 32'd0);
        check_val("t1_ext", 32'(event_extended), 32'd0);
        check_val("t1_level", 32'(fifo_level), 32'd1);
        tick(HALF - SYNC_STAGES - 3);
        ps2_clk = 1'b1;
        drain();

        // 2: break and extended-break prefixes
        send_frame(8'hF0);
        send_frame(8'h1C);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        tick(4);
        check_val("t2_level", 32'(fifo_level), 32'd2);
        drain();

        // 3: bad parity rejected, next frame fine
        base = ferr_seen;
        send_frame(8'h1C, 1);
        tick(4);
        check_val("t3_ferr", 32'(ferr_seen), 32'(base + 1));
        check_val("t3_level", 32'(fifo_level), 32'd0);
        send_frame(8'h32);
        drain();

        // 4: partial frame after an E0 prefix aborted by the watchdog
        send_frame(8'hE0);
        base = ferr_seen;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        tick(TIMEOUT_CYCLES + 10);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_val("t4_ferr", 32'(ferr_seen), 32'(base + 1));
        check_val("t4_state", 32'(frame_state), 32'(IDLE));
        send_frame(8'h29);
        drain();

        // 5: overflow on the ninth code while the consumer stalls
        base = ovf_seen;
        for (int i = 1; i <= 8; i++) send_frame(8'(i));
        check_val("t5_no_ovf_yet", 32'(ovf_seen), 32'(base));
        send_frame(8'h09);
        tick(2);
        check_val("t5_ovf", 32'(ovf_seen), 32'(base + 1));
        check_val("t5_level", 32'(fifo_level), 32'd8);
        drain();

        // 6: push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) send_frame(8'(8'h11 + i));
        base = ovf_seen;
        send_frame(8'h0A, 0, 1);
        tick(2);
        check_val("t6_no_ovf", 32'(ovf_seen), 32'(base));
        check_val("t6_level", 32'(fifo_level), 32'd8);
        check_val("t6_head", 32'(event_code), 32'(exp_q[0][7:0]));
        drain();

        // 7: reset in the middle of a frame
        send_frame(8'hE0);
        send_frame(8'h5A);
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        tick(1);
        check_val("t7_valid", 32'(event_valid), 32'd0);
        check_val("t7_code", 32'(event_code), 32'd0);
        check_val("t7_ext", 32'(event_extended), 32'd0);
        check_val("t7_ferr", 32'(frame_error), 32'd0);
        check_val("t7_ovf", 32'(overflow), 32'd0);
        check_val("t7_level", 32'(fifo_level), 32'd0);
        check_val("t7_state", 32'(frame_state), 32'(IDLE));
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        send_frame(8'h66);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
